// File: rtl/uart_boot_loader.sv
// UART program loader: receives a framed, checksummed image over 8N1 serial,
// writes it into an instruction memory and releases the CPU once it verifies.
module uart_boot_loader #(
    parameter int CLK_FREQ      = 27000000,
    parameter int BAUD          = 115200,
    parameter int ADDR_WIDTH    = 8,
    parameter int WORD_BYTES    = 4,
    parameter int TIMEOUT_BYTES = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      uart_rx,
    input  logic [ADDR_WIDTH-1:0]     rom_address,
    output logic [8*WORD_BYTES-1:0]   rom_data,
    output logic                      cpu_enable,
    output logic                      busy,
    output logic                      error,
    output logic [ADDR_WIDTH:0]       words_loaded
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int DEPTH        = 2 ** ADDR_WIDTH;
    localparam int DATA_WIDTH   = 8 * WORD_BYTES;
    localparam int TIMEOUT_CLKS = TIMEOUT_BYTES * 10 * CLKS_PER_BIT;
    localparam int BIT_CNT_W    = $clog2(CLKS_PER_BIT);
    localparam int TO_CNT_W     = $clog2(TIMEOUT_CLKS + 1);
    localparam int BIDX_W       = $clog2(WORD_BYTES + 1);

    localparam logic [7:0]          SYNC_BYTE = 8'hA5;
    localparam logic [ADDR_WIDTH:0] WCNT_ONE  = 1;

    localparam logic [1:0] RX_IDLE  = 2'd0;
    localparam logic [1:0] RX_START = 2'd1;
    localparam logic [1:0] RX_DATA  = 2'd2;
    localparam logic [1:0] RX_STOP  = 2'd3;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LEN_LO = 3'd1;
    localparam logic [2:0] ST_LEN_HI = 3'd2;
    localparam logic [2:0] ST_DATA   = 3'd3;
    localparam logic [2:0] ST_CHECK  = 3'd4;
    localparam logic [2:0] ST_DONE   = 3'd5;

    // ------------------------------------------------------------------
    // Serial receiver
    // ------------------------------------------------------------------
    logic                 rx_meta_q, rx_sync_q, rx_prev_q;
    logic [1:0]           rx_state_q, rx_state_d;
    logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [2:0]           bit_idx_q, bit_idx_d;
    logic [7:0]           shift_q, shift_d;
    logic                 byte_valid_q, byte_valid_d;
    logic                 frame_err_q, frame_err_d;
    logic                 bit_tick, half_tick;

    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= uart_rx;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
        end
    end

    assign bit_tick  = (bit_cnt_q == BIT_CNT_W'(CLKS_PER_BIT - 1));
    assign half_tick = (bit_cnt_q == BIT_CNT_W'(HALF_BIT - 1));

    // NOTE: every variable gets a default at the top of always_comb so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        rx_state_d   = rx_state_q;
        bit_cnt_d    = bit_cnt_q;
        bit_idx_d    = bit_idx_q;
        shift_d      = shift_q;
        byte_valid_d = 1'b0;
        frame_err_d  = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                if (rx_prev_q && !rx_sync_q) begin
                    rx_state_d = RX_START;
                    bit_cnt_d  = '0;
                end
            end
            RX_START: begin
                if (half_tick) begin
                    bit_cnt_d  = '0;
                    bit_idx_d  = '0;
                    rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
                end else begin
                    bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
                end
            end
            RX_DATA: begin
                if (bit_tick) begin
                    bit_cnt_d = '0;
                    shift_d   = {rx_sync_q, shift_q[7:1]};
                    if (bit_idx_q == 3'd7) rx_state_d = RX_STOP;
                    else                   bit_idx_d  = bit_idx_q + 3'd1;
                end else begin
                    bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
                end
            end
            default: begin
                if (bit_tick) begin
                    bit_cnt_d    = '0;
                    rx_state_d   = RX_IDLE;
                    byte_valid_d = rx_sync_q;
                    frame_err_d  = !rx_sync_q;
                end else begin
                    bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_state_q   <= RX_IDLE;
            bit_cnt_q    <= '0;
            bit_idx_q    <= '0;
            shift_q      <= '0;
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            rx_state_q   <= rx_state_d;
            bit_cnt_q    <= bit_cnt_d;
            bit_idx_q    <= bit_idx_d;
            shift_q      <= shift_d;
            byte_valid_q <= byte_valid_d;
            frame_err_q  <= frame_err_d;
        end
    end

    // ------------------------------------------------------------------
    // Frame loader
    // ------------------------------------------------------------------
    logic [2:0]            state_q, state_d;
    logic                  cpu_en_q, cpu_en_d;
    logic                  busy_q, busy_d;
    logic                  err_q, err_d;
    logic [ADDR_WIDTH:0]   wl_q, wl_d;
    logic [7:0]            len_lo_q, len_lo_d;
    logic [ADDR_WIDTH:0]   len_q, len_d;
    logic [ADDR_WIDTH:0]   wcount_q, wcount_d;
    logic [BIDX_W-1:0]     bidx_q, bidx_d;
    logic [DATA_WIDTH-1:0] word_q, word_d;
    logic [7:0]            csum_q, csum_d;
    logic                  wr_pend_q, wr_pend_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [TO_CNT_W-1:0]   to_q, to_d;

    logic [7:0]            rx_byte;
    logic [15:0]           len_word;
    logic                  len_bad;
    logic                  timeout_hit;
    logic [DATA_WIDTH-1:0] word_next;
    logic [ADDR_WIDTH:0]   wcount_inc;

    assign rx_byte     = shift_q;
    assign len_word    = {rx_byte, len_lo_q};
    assign len_bad     = (len_word == 16'd0) || ({16'd0, len_word} > 32'(DEPTH));
    assign timeout_hit = busy_q && !byte_valid_q && (to_q == TO_CNT_W'(TIMEOUT_CLKS - 1));
    // Little-endian assembly: each byte enters at the top and drifts down,
    // so the first byte of a word ends up in bits [7:0].
    assign word_next   = (word_q >> 8) | (DATA_WIDTH'(rx_byte) << (DATA_WIDTH - 8));
    assign wcount_inc  = wcount_q + WCNT_ONE;

    always_comb begin
        state_d   = state_q;
        cpu_en_d  = cpu_en_q;
        busy_d    = busy_q;
        err_d     = err_q;
        wl_d      = wl_q;
        len_lo_d  = len_lo_q;
        len_d     = len_q;
        wcount_d  = wcount_q;
        bidx_d    = bidx_q;
        word_d    = word_q;
        csum_d    = csum_q;
        wr_pend_d = 1'b0;
        addr_d    = wr_pend_q ? addr_q + ADDR_WIDTH'(1) : addr_q;
        to_d      = (!busy_q || byte_valid_q) ? '0 : to_q + TO_CNT_W'(1);

        if (byte_valid_q) begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (rx_byte == SYNC_BYTE) begin
                        state_d  = ST_LEN_LO;
                        cpu_en_d = 1'b0;
                        busy_d   = 1'b1;
                        err_d    = 1'b0;
                        addr_d   = '0;
                        csum_d   = '0;
                        wcount_d = '0;
                        bidx_d   = '0;
                    end
                end
                ST_LEN_LO: begin
                    len_lo_d = rx_byte;
                    state_d  = ST_LEN_HI;
                end
                ST_LEN_HI: begin
                    if (len_bad) begin
                        err_d   = 1'b1;
                        busy_d  = 1'b0;
                        state_d = ST_IDLE;
                    end else begin
                        len_d   = (ADDR_WIDTH+1)'(len_word);
                        state_d = ST_DATA;
                    end
                end
                ST_DATA: begin
                    csum_d = csum_q + rx_byte;
                    word_d = word_next;
                    if (bidx_q == BIDX_W'(WORD_BYTES - 1)) begin
                        bidx_d    = '0;
                        wr_pend_d = 1'b1;
                        wcount_d  = wcount_inc;
                        if (wcount_inc == len_q) state_d = ST_CHECK;
                    end else begin
                        bidx_d = bidx_q + BIDX_W'(1);
                    end
                end
                ST_CHECK: begin
                    busy_d = 1'b0;
                    if (rx_byte == csum_q) begin
                        cpu_en_d = 1'b1;
                        wl_d     = len_q;
                        state_d  = ST_DONE;
                    end else begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end else if ((frame_err_q && busy_q) || timeout_hit) begin
            err_d   = 1'b1;
            busy_d  = 1'b0;
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            cpu_en_q  <= 1'b0;
            busy_q    <= 1'b0;
            err_q     <= 1'b0;
            wl_q      <= '0;
            len_lo_q  <= '0;
            len_q     <= '0;
            wcount_q  <= '0;
            bidx_q    <= '0;
            word_q    <= '0;
            csum_q    <= '0;
            wr_pend_q <= 1'b0;
            addr_q    <= '0;
            to_q      <= '0;
        end else begin
            state_q   <= state_d;
            cpu_en_q  <= cpu_en_d;
            busy_q    <= busy_d;
            err_q     <= err_d;
            wl_q      <= wl_d;
            len_lo_q  <= len_lo_d;
            len_q     <= len_d;
            wcount_q  <= wcount_d;
            bidx_q    <= bidx_d;
            word_q    <= word_d;
            csum_q    <= csum_d;
            wr_pend_q <= wr_pend_d;
            addr_q    <= addr_d;
            to_q      <= to_d;
        end
    end

    // ------------------------------------------------------------------
    // Instruction memory
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // NOTE: the memory array has no reset; contents survive reset so a
    // partial image is still visible, and it maps cleanly onto RAM blocks.
    always_ff @(posedge clk) begin
        if (wr_pend_q) mem[addr_q] <= word_q;
    end

    assign rom_data     = mem[rom_address];
    assign cpu_enable   = cpu_en_q;
    assign busy         = busy_q;
    assign error        = err_q;
    assign words_loaded = wl_q;

endmodule

// File: tb/tb_uart_boot_loader.sv
// Self-checking bench for uart_boot_loader: drives serial frames and compares
// the loader's outputs and memory against a frame-level model.
`timescale 1ns/1ps
module tb_uart_boot_loader;

    localparam int CPB   = 16;
    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        uart_rx;
    logic [3:0]  rom_address;
    logic [31:0] rom_data;
    logic        cpu_enable, busy, error;
    logic [4:0]  words_loaded;

    int n_checks = 0;
    int n_pass   = 0;

    // Frame-level reference model
    logic [31:0] exp_mem   [DEPTH];
    bit          exp_valid [DEPTH];
    logic        exp_cpu, exp_err;
    logic [4:0]  exp_wl;
    logic [31:0] fw        [DEPTH];

    always #5 clk = ~clk;

    uart_boot_loader #(
        .CLK_FREQ(16), .BAUD(1), .ADDR_WIDTH(4), .WORD_BYTES(4), .TIMEOUT_BYTES(16)
    ) dut (
        .clk(clk), .reset(reset), .uart_rx(uart_rx), .rom_address(rom_address),
        .rom_data(rom_data), .cpu_enable(cpu_enable), .busy(busy), .error(error),
        .words_loaded(words_loaded)
    );

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic settle();
        tick(2);
        @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        @(posedge clk);
        uart_rx = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            tick(CPB);
        end
        uart_rx = stop_bit;
        tick(CPB);
        uart_rx = 1'b1;
        if (!stop_bit) tick(CPB);
    endtask

    // Sends a whole frame of n words from fw[] and updates the model.
    task automatic load_frame(input int n, input bit good);
        logic [7:0] sum;
        logic [15:0] len;
        logic [31:0] w;
        sum = 8'd0;
        len = 16'(n);
        send_byte(8'hA5, 1'b1);
        send_byte(len[7:0], 1'b1);
        send_byte(len[15:8], 1'b1);
        for (int i = 0; i < n; i++) begin
            w = fw[i];
            for (int b = 0; b < 4; b++) begin
                sum = sum + w[8*b +: 8];
                send_byte(w[8*b +: 8], 1'b1);
            end
        end
        send_byte(good ? sum : sum + 8'd1, 1'b1);
        settle();
        for (int i = 0; i < n; i++) begin
            exp_mem[i]   = fw[i];
            exp_valid[i] = 1'b1;
        end
        if (good) begin
            exp_cpu = 1'b1; exp_err = 1'b0; exp_wl = 5'(n);
        end else begin
            exp_cpu = 1'b0; exp_err = 1'b1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; uart_rx = 1'b1; rom_address = '0;
        tick(3);
        @(negedge clk);
        n_checks++; if (cpu_enable !== 1'b0) $display("FAIL reset_cpu_enable: got %b want 0", cpu_enable); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
        n_checks++; if (error !== 1'b0) $display("FAIL reset_error: got %b want 0", error); else n_pass++;
        n_checks++; if (words_loaded !== 5'd0) $display("FAIL reset_words_loaded: got %0d want 0", words_loaded); else n_pass++;
        reset = 1'b1;
        exp_cpu = 1'b0; exp_err = 1'b0; exp_wl = '0;
        for (int i = 0; i < DEPTH; i++) exp_valid[i] = 1'b0;
        tick(5);
    endtask

    task automatic test_good_load();
        fw[0] = 32'h12345678; fw[1] = 32'hDEADBEEF;
        load_frame(2, 1'b1);
        n_checks++; if (cpu_enable !== 1'b1) $display("FAIL good_cpu_enable: got %b want 1", cpu_enable); else n_pass++;
        n_checks++; if (words_loaded !== 5'd2) $display("FAIL good_words_loaded: got %0d want 2", words_loaded); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL good_busy: got %b want 0", busy); else n_pass++;
        n_checks++; if (error !== 1'b0) $display("FAIL good_error: got %b want 0", error); else n_pass++;
        rom_address = 4'd0; #1;
        n_checks++; if (rom_data !== 32'h12345678) $display("FAIL good_mem0: got %h want 12345678", rom_data); else n_pass++;
        rom_address = 4'd1; #1;
        n_checks++; if (rom_data !== 32'hDEADBEEF) $display("FAIL good_mem1: got %h want deadbeef", rom_data); else n_pass++;
    endtask

    task automatic test_bad_checksum();
        fw[0] = 32'hCAFEF00D; fw[1] = 32'h0BADC0DE;
        load_frame(2, 1'b0);
        n_checks++; if (error !== 1'b1) $display("FAIL badchk_error: got %b want 1", error); else n_pass++;
        n_checks++; if (cpu_enable !== 1'b0) $display("FAIL badchk_cpu_enable: got %b want 0", cpu_enable); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL badchk_busy: got %b want 0", busy); else n_pass++;
        n_checks++; if (words_loaded !== exp_wl) $display("FAIL badchk_words_loaded: got %0d want %0d", words_loaded, exp_wl); else n_pass++;
        for (int i = 0; i < 2; i++) begin
            rom_address = 4'(i); #1;
            n_checks++; if (rom_data !== exp_mem[i]) $display("FAIL badchk_mem%0d: got %h want %h", i, rom_data, exp_mem[i]); else n_pass++;
        end
    endtask

    task automatic test_length_error();
        send_byte(8'hA5, 1'b1);
        settle();
        n_checks++; if (busy !== 1'b1 || error !== 1'b0) $display("FAIL len_sync_accept: got busy=%b error=%b want busy=1 error=0", busy, error); else n_pass++;
        send_byte(8'h11, 1'b1);
        send_byte(8'h00, 1'b1);
        settle();
        n_checks++; if (error !== 1'b1) $display("FAIL len17_error: got %b want 1", error); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL len17_busy: got %b want 0", busy); else n_pass++;
        for (int i = 0; i < 2; i++) begin
            rom_address = 4'(i); #1;
            n_checks++; if (rom_data !== exp_mem[i]) $display("FAIL len17_mem%0d: got %h want %h", i, rom_data, exp_mem[i]); else n_pass++;
        end
        send_byte(8'hA5, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);
        settle();
        n_checks++; if (error !== 1'b1 || busy !== 1'b0) $display("FAIL len0_error: got error=%b busy=%b want error=1 busy=0", error, busy); else n_pass++;
        exp_err = 1'b1;
    endtask

    // A short low glitch right after the sync byte must not count as a byte,
    // otherwise the length fields that follow would be shifted.
    task automatic test_false_start();
        logic [31:0] w;
        logic [7:0] sum;
        w = $urandom;
        sum = w[7:0] + w[15:8] + w[23:16] + w[31:24];
        send_byte(8'hA5, 1'b1);
        @(posedge clk);
        uart_rx = 1'b0; tick(4); uart_rx = 1'b1;
        tick(200);
        @(negedge clk);
        n_checks++; if (busy !== 1'b1 || error !== 1'b0) $display("FAIL glitch_state: got busy=%b error=%b want busy=1 error=0", busy, error); else n_pass++;
        send_byte(8'h01, 1'b1);
        send_byte(8'h00, 1'b1);
        for (int b = 0; b < 4; b++) send_byte(w[8*b +: 8], 1'b1);
        send_byte(sum, 1'b1);
        settle();
        exp_mem[0] = w; exp_valid[0] = 1'b1; exp_cpu = 1'b1; exp_err = 1'b0; exp_wl = 5'd1;
        n_checks++; if (cpu_enable !== 1'b1 || words_loaded !== 5'd1) $display("FAIL glitch_load: got cpu_enable=%b words_loaded=%0d want 1/1", cpu_enable, words_loaded); else n_pass++;
        rom_address = 4'd0; #1;
        n_checks++; if (rom_data !== w) $display("FAIL glitch_mem0: got %h want %h", rom_data, w); else n_pass++;
    endtask

    task automatic test_framing();
        logic [31:0] w;
        w = $urandom;
        send_byte(8'hA5, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'h00, 1'b1);
        for (int b = 0; b < 4; b++) send_byte(w[8*b +: 8], 1'b1);
        send_byte(8'h3C, 1'b0);
        settle();
        exp_mem[0] = w; exp_cpu = 1'b0; exp_err = 1'b1;
        n_checks++; if (error !== 1'b1) $display("FAIL frame_error: got %b want 1", error); else n_pass++;
        n_checks++; if (busy !== 1'b0 || cpu_enable !== 1'b0) $display("FAIL frame_state: got busy=%b cpu_enable=%b want 0/0", busy, cpu_enable); else n_pass++;
        rom_address = 4'd0; #1;
        n_checks++; if (rom_data !== w) $display("FAIL frame_partial_mem0: got %h want %h", rom_data, w); else n_pass++;
        fw[0] = $urandom;
        load_frame(1, 1'b1);
        n_checks++; if (error !== 1'b0 || cpu_enable !== 1'b1) $display("FAIL frame_recover: got error=%b cpu_enable=%b want 0/1", error, cpu_enable); else n_pass++;
        rom_address = 4'd0; #1;
        n_checks++; if (rom_data !== fw[0]) $display("FAIL frame_recover_mem0: got %h want %h", rom_data, fw[0]); else n_pass++;
    endtask

    task automatic test_timeout();
        send_byte(8'hA5, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h00, 1'b1);
        tick(2400);
        @(negedge clk);
        n_checks++; if (error !== 1'b0 || busy !== 1'b1) $display("FAIL timeout_early: got error=%b busy=%b want 0/1", error, busy); else n_pass++;
        tick(300);
        @(negedge clk);
        n_checks++; if (error !== 1'b1) $display("FAIL timeout_error: got %b want 1", error); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL timeout_busy: got %b want 0", busy); else n_pass++;
        exp_cpu = 1'b0; exp_err = 1'b1;
        send_byte(8'h5A, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'hFF, 1'b1);
        settle();
        n_checks++; if (busy !== 1'b0 || error !== 1'b1 || cpu_enable !== 1'b0) $display("FAIL stray_bytes: got busy=%b error=%b cpu_enable=%b want 0/1/0", busy, error, cpu_enable); else n_pass++;
    endtask

    task automatic test_reload();
        logic [31:0] w;
        logic [7:0] sum;
        fw[0] = $urandom; fw[1] = $urandom;
        load_frame(2, 1'b1);
        n_checks++; if (cpu_enable !== 1'b1) $display("FAIL reload_pre_cpu_enable: got %b want 1", cpu_enable); else n_pass++;
        fork
            send_byte(8'hA5, 1'b1);
            begin
                bit seen;
                logic prev_cpu;
                seen = 1'b0;
                prev_cpu = cpu_enable;
                for (int i = 0; i < 300 && !seen; i++) begin
                    @(negedge clk);
                    if (busy === 1'b1) begin
                        seen = 1'b1;
                        n_checks++;
                        if (cpu_enable !== 1'b0 || prev_cpu !== 1'b1)
                            $display("FAIL reload_edge: got cpu_enable=%b (prev %b) want 0 (prev 1)", cpu_enable, prev_cpu);
                        else n_pass++;
                    end
                    prev_cpu = cpu_enable;
                end
                if (!seen) begin
                    n_checks++;
                    $display("FAIL reload_busy_timeout: got busy=%b want 1 within 300 clocks", busy);
                end
            end
        join
        w = $urandom;
        sum = w[7:0] + w[15:8] + w[23:16] + w[31:24];
        send_byte(8'h01, 1'b1);
        send_byte(8'h00, 1'b1);
        settle();
        n_checks++; if (cpu_enable !== 1'b0 || busy !== 1'b1) $display("FAIL reload_halted: got cpu_enable=%b busy=%b want 0/1", cpu_enable, busy); else n_pass++;
        for (int b = 0; b < 4; b++) send_byte(w[8*b +: 8], 1'b1);
        send_byte(sum, 1'b1);
        settle();
        exp_mem[0] = w; exp_cpu = 1'b1; exp_err = 1'b0; exp_wl = 5'd1;
        n_checks++; if (cpu_enable !== 1'b1 || words_loaded !== 5'd1) $display("FAIL reload_done: got cpu_enable=%b words_loaded=%0d want 1/1", cpu_enable, words_loaded); else n_pass++;
        rom_address = 4'd0; #1;
        n_checks++; if (rom_data !== w) $display("FAIL reload_mem0: got %h want %h", rom_data, w); else n_pass++;
    endtask

    task automatic test_random_loads();
        for (int t = 0; t < 4; t++) begin
            int n;
            bit good;
            n = $urandom_range(1, 8);
            good = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < n; i++) fw[i] = $urandom;
            load_frame(n, good);
            n_checks++; if (cpu_enable !== exp_cpu) $display("FAIL rand%0d_cpu_enable: got %b want %b", t, cpu_enable, exp_cpu); else n_pass++;
            n_checks++; if (error !== exp_err) $display("FAIL rand%0d_error: got %b want %b", t, error, exp_err); else n_pass++;
            n_checks++; if (busy !== 1'b0) $display("FAIL rand%0d_busy: got %b want 0", t, busy); else n_pass++;
            n_checks++; if (words_loaded !== exp_wl) $display("FAIL rand%0d_words_loaded: got %0d want %0d", t, words_loaded, exp_wl); else n_pass++;
            for (int i = 0; i < DEPTH; i++) begin
                if (exp_valid[i]) begin
                    rom_address = 4'(i); #1;
                    n_checks++; if (rom_data !== exp_mem[i]) $display("FAIL rand%0d_mem%0d: got %h want %h", t, i, rom_data, exp_mem[i]); else n_pass++;
                end
            end
        end
    endtask

    task automatic test_reset_mid_load();
        logic [31:0] w;
        w = $urandom;
        send_byte(8'hA5, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'h00, 1'b1);
        for (int b = 0; b < 4; b++) send_byte(w[8*b +: 8], 1'b1);
        @(posedge clk);
        uart_rx = 1'b0;
        tick(20);
        @(negedge clk);
        n_checks++; if (busy !== 1'b1) $display("FAIL rst_pre_busy: got %b want 1", busy); else n_pass++;
        @(posedge clk);
        #3 reset = 1'b0;
        #1;
        n_checks++; if (busy !== 1'b0) $display("FAIL rst_async_busy: got %b want 0", busy); else n_pass++;
        n_checks++; if (cpu_enable !== 1'b0 || error !== 1'b0) $display("FAIL rst_async_flags: got cpu_enable=%b error=%b want 0/0", cpu_enable, error); else n_pass++;
        n_checks++; if (words_loaded !== 5'd0) $display("FAIL rst_async_words_loaded: got %0d want 0", words_loaded); else n_pass++;
        uart_rx = 1'b1;
        tick(3);
        #2 reset = 1'b1;
        tick(5);
        exp_mem[0] = w; exp_cpu = 1'b0; exp_err = 1'b0; exp_wl = '0;
        rom_address = 4'd0; #1;
        n_checks++; if (rom_data !== w) $display("FAIL rst_mem_kept: got %h want %h", rom_data, w); else n_pass++;
        for (int i = 0; i < 3; i++) fw[i] = $urandom;
        load_frame(3, 1'b1);
        n_checks++; if (cpu_enable !== 1'b1 || words_loaded !== 5'd3) $display("FAIL rst_recover: got cpu_enable=%b words_loaded=%0d want 1/3", cpu_enable, words_loaded); else n_pass++;
        rom_address = 4'd2; #1;
        n_checks++; if (rom_data !== fw[2]) $display("FAIL rst_recover_mem2: got %h want %h", rom_data, fw[2]); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_good_load();
        test_bad_checksum();
        test_length_error();
        test_false_start();
        test_framing();
        test_timeout();
        test_reload();
        test_random_loads();
        test_reset_mid_load();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation exceeded 5 ms, %0d/%0d checks passed so far", n_pass, n_checks);
        $fatal(1, "watchdog expired");
    end

endmodule
